// File: rtl/fft_bfly_seq.sv
// fft_bfly_seq: read-side sequencer for a 2^LOG2N-point radix-2 DIT FFT.
// Walks every stage and butterfly of an in-place transform. For each
// butterfly it emits two data-RAM addresses and one twiddle-table address.
// The twiddle table itself lives outside this block.
//
// Optional build macro: FFT_BITREV_LOAD_EN
//   When defined, a LOAD phase runs before the butterflies. In LOAD the
//   block produces bit-reversed write addresses for the incoming samples.
//
// Ports
//   clk       in   clock; all state updates on the rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a transform; only looked at in IDLE
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse when the transform completes
//   bf_valid  out  butterfly descriptor valid
//   bf_ready  in   datapath accepts the descriptor
//   addr_a    out  upper-leg data address
//   addr_b    out  lower-leg data address
//   tw_addr   out  twiddle index; W = exp(-j*2*pi*tw_addr/2^LOG2N)
//   stage     out  current stage, 0..LOG2N-1
//   last_bf   out  high with the final descriptor of a stage
//   in_valid  in   (FFT_BITREV_LOAD_EN) input sample strobe
//   ld_we     out  (FFT_BITREV_LOAD_EN) sample write enable
//   ld_addr   out  (FFT_BITREV_LOAD_EN) bit-reversed sample write address
//
// State  | meaning
// IDLE   | waiting for start
// LOAD   | bit-reversed sample load (FFT_BITREV_LOAD_EN builds only)
// RUN    | presenting butterfly descriptors to the datapath
// DRAIN  | PIPE_DRAIN idle cycles between stages, so writeback can finish
// DONE   | one-cycle done pulse
module fft_bfly_seq #(
  parameter int LOG2N      = 7,
  parameter int PIPE_DRAIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic [2:0]       stage,
  output logic             last_bf
`ifdef FFT_BITREV_LOAD_EN
  ,
  input  logic             in_valid,
  output logic             ld_we,
  output logic [LOG2N-1:0] ld_addr
`endif
);

  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0]    K_ONES     = '1;
  localparam logic [LOG2N-1:0] ONE        = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [2:0]       S_LAST     = 3'(LOG2N - 1);
  localparam bit               HAS_DRAIN  = (PIPE_DRAIN > 0);
  localparam logic [3:0]       DRAIN_INIT = 4'((PIPE_DRAIN > 0) ? PIPE_DRAIN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
`ifdef FFT_BITREV_LOAD_EN
    , S_LOAD
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0]    s_q, s_d;
  logic [3:0]    drain_q, drain_d;
`ifdef FFT_BITREV_LOAD_EN
  logic [LOG2N-1:0] n_q, n_d;
`endif

  logic [LOG2N-1:0] addr_a_q, addr_b_q;
  logic [KW-1:0]    tw_q;
  logic [2:0]       stage_q;
  logic             last_q;

  // Descriptor for the butterfly that will be presented next cycle.
  logic [LOG2N-1:0] half_d, addr_a_d, addr_b_d;
  logic [KW-1:0]    pos_d, grp_d, tw_d;
  logic [3:0]       grp_sh, tw_sh;
  logic             last_d;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    drain_d = drain_q;
`ifdef FFT_BITREV_LOAD_EN
    n_d     = n_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d = '0;
          s_d = '0;
`ifdef FFT_BITREV_LOAD_EN
          n_d     = '0;
          state_d = S_LOAD;
`else
          state_d = S_RUN;
`endif
        end
      end
`ifdef FFT_BITREV_LOAD_EN
      S_LOAD: begin
        if (in_valid) begin
          n_d = n_q + ONE;
          if (n_q == '1) state_d = S_RUN;
        end
      end
`endif
      S_RUN: begin
        if (bf_ready) begin
          if (k_q == K_ONES) begin
            k_d = '0;
            if (HAS_DRAIN) begin
              state_d = S_DRAIN;
              drain_d = DRAIN_INIT;
            end else if (s_q == S_LAST) begin
              state_d = S_DONE;
            end else begin
              s_d = s_q + 3'd1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) begin
          if (s_q == S_LAST) begin
            state_d = S_DONE;
          end else begin
            s_d     = s_q + 3'd1;
            state_d = S_RUN;
          end
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address generation for the next butterfly.
  // pos = k mod 2^s, grp = k >> s; addr_a = grp*2^(s+1) + pos.
  always_comb begin
    half_d   = ONE << s_d;
    pos_d    = k_d & ~(K_ONES << s_d);
    grp_d    = k_d >> s_d;
    grp_sh   = {1'b0, s_d} + 4'd1;
    addr_a_d = ({1'b0, grp_d} << grp_sh) | {1'b0, pos_d};
    addr_b_d = addr_a_d | half_d;
    tw_sh    = 4'(LOG2N - 1) - {1'b0, s_d};
    tw_d     = pos_d << tw_sh;
    last_d   = (k_d == K_ONES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      s_q      <= '0;
      drain_q  <= '0;
`ifdef FFT_BITREV_LOAD_EN
      n_q      <= '0;
`endif
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      stage_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      drain_q <= drain_d;
`ifdef FFT_BITREV_LOAD_EN
      n_q     <= n_d;
`endif
      // Reloading while stalled writes back identical values, which keeps
      // the descriptor stable. Outside RUN the outputs hold their last values.
      if (state_d == S_RUN) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
        tw_q     <= tw_d;
        stage_q  <= s_d;
        last_q   <= last_d;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign bf_valid = (state_q == S_RUN);
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_addr  = tw_q;
  assign stage    = stage_q;
  assign last_bf  = last_q;

`ifdef FFT_BITREV_LOAD_EN
  logic [LOG2N-1:0] n_rev;
  always_comb begin
    n_rev = '0;
    for (int i = 0; i < LOG2N; i++) n_rev[i] = n_q[LOG2N-1-i];
  end
  assign ld_we   = (state_q == S_LOAD) && in_valid;
  assign ld_addr = n_rev;
`endif

endmodule

// File: tb/tb_fft_bfly_seq.sv
module tb_fft_bfly_seq;
  localparam int LOG2N      = 7;
  localparam int PIPE_DRAIN = 4;
  localparam int NB         = 2 ** (LOG2N - 1);
`ifdef FFT_BITREV_LOAD_EN
  localparam int LOAD_CYC   = 2 ** LOG2N;
`else
  localparam int LOAD_CYC   = 0;
`endif
  localparam int RUN_CYC    = 1 + LOG2N * (NB + PIPE_DRAIN) + LOAD_CYC;

  logic             clk = 1'b0;
  logic             rst_n, start, bf_ready;
  logic             busy, done, bf_valid, last_bf;
  logic [LOG2N-1:0] addr_a, addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic [2:0]       stage;
`ifdef FFT_BITREV_LOAD_EN
  logic             in_valid = 1'b1;
  logic             ld_we;
  logic [LOG2N-1:0] ld_addr;
`endif

  int n_vec = 0;
  int n_err = 0;

  fft_bfly_seq #(.LOG2N(LOG2N), .PIPE_DRAIN(PIPE_DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .addr_a(addr_a), .addr_b(addr_b),
    .tw_addr(tw_addr), .stage(stage), .last_bf(last_bf)
`ifdef FFT_BITREV_LOAD_EN
    , .in_valid(in_valid), .ld_we(ld_we), .ld_addr(ld_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference butterfly addressing in plain integer arithmetic.
  function automatic void exp_desc(input int s, input int k, output int a, output int b,
                                   output int tw);
    int half;
    half = 2 ** s;
    a  = (k / half) * 2 * half + (k % half);
    b  = a + half;
    tw = (k % half) * (2 ** (LOG2N - 1 - s));
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_valid"}, 32'(bf_valid), 0);
    chk({tag, "_a"},     32'(addr_a), 0);
    chk({tag, "_b"},     32'(addr_b), 0);
    chk({tag, "_tw"},    32'(tw_addr), 0);
    chk({tag, "_stage"}, 32'(stage), 0);
    chk({tag, "_last"},  32'(last_bf), 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall at s=2,k=10
  // noise: random start pulses while busy, and start high in the done cycle
  // abort_s >= 0: assert reset mid-stage abort_s
  task automatic run_xfer(input int mode, input bit noise, input int abort_s);
    int s_e = 0, k_e = 0, edges = 0, stalls = 0, gap = 0, held = 0;
    int ea, eb, et;
    bit fin = 0, prev_v = 0, aborted = 0;
    start    = 1'b1;
    bf_ready = 1'b1;
    while (!fin) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (mode == 1) bf_ready = 1'($urandom_range(0, 1));
      if (edges > 4000) begin
        chk("timeout", 32'(edges), 32'(RUN_CYC));
        fin = 1;
      end else if (bf_valid) begin
        if (!prev_v && s_e > 0) chk("drain_gap", 32'(gap), 32'(PIPE_DRAIN));
        gap = 0;
        exp_desc(s_e, k_e, ea, eb, et);
        chk("addr_a",  32'(addr_a),  32'(ea));
        chk("addr_b",  32'(addr_b),  32'(eb));
        chk("tw_addr", 32'(tw_addr), 32'(et));
        chk("stage",   32'(stage),   32'(s_e));
        chk("last_bf", 32'(last_bf), 32'(k_e == NB - 1));
        chk("busy_run", 32'(busy), 1);
        chk("done_run", 32'(done), 0);
        case (mode)
          1:       bf_ready = ($urandom_range(0, 3) != 0);
          2:       bf_ready = !(s_e == 2 && k_e == 10 && held < 3);
          default: bf_ready = 1'b1;
        endcase
        if (!bf_ready) begin
          stalls++;
          held++;
        end else begin
          k_e++;
          if (k_e == NB) begin
            k_e = 0;
            s_e++;
          end
        end
        if (abort_s == s_e && k_e == 7) begin
          rst_n = 1'b0;
          #1;
          chk_zero("abort");
          fin     = 1;
          aborted = 1;
        end
      end else if (done) begin
        chk("done_cycles", 32'(edges), 32'(RUN_CYC + stalls));
        chk("beats",       32'(s_e),   32'(LOG2N));
        chk("final_gap",   32'(gap),   32'(PIPE_DRAIN));
        chk("busy_done",   32'(busy),  1);
        if (noise) start = 1'b1;
        fin = 1;
      end else if (busy) begin
        gap++;
      end
      prev_v = bf_valid;
    end
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
      end
      start    = 1'b0;
      bf_ready = 1'b1;
      rst_n    = 1'b1;
      @(negedge clk);
    end else begin
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      bf_ready = 1'b1;
      chk("pulse_done", 32'(done), 0);
      chk("idle_busy",  32'(busy), 0);
      @(negedge clk);
      chk("idle_hold",  32'(busy), 0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    bf_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 0);

    run_xfer(0, 1'b0, -1);
    run_xfer(2, 1'b0, -1);
    run_xfer(1, 1'b1, -1);
    run_xfer(0, 1'b1, -1);
    run_xfer(0, 1'b0, 3);
    run_xfer(0, 1'b0, -1);
    run_xfer(1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
